pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter LD_STALL_EXEC, default 2: bubble count when a load in EXEC feeds the RF-stage instruction.
REQ-002 Parameter LD_STALL_MEM, default 1: bubble count when a load in MEM feeds the RF-stage instruction.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 ra_rf, rb_rf  in  5 each  source register fields of the RF-stage instruction.
REQ-006 use_ra_rf, use_rb_rf  in  1 each  RF-stage instruction reads ra / rb.
REQ-007 ld_exec, ld_mem  in  1 each  EXEC / MEM instruction is LD or LDR.
REQ-008 rc_exec, rc_mem  in  5 each  destination fields in EXEC / MEM.
REQ-009 br_taken_rf  in  1  RF-stage branch or JMP resolved taken.
REQ-010 ill_op_rf  in  1  RF-stage opcode is illegal.
REQ-011 irq  in  1  level-sensitive interrupt request.
REQ-012 sup_rf  in  1  RF-stage PC has supervisor bit 31 set.
REQ-013 stall_if, stall_rf  out  1 each  hold the IF / RF pipeline registers.
REQ-014 ir_src_if, ir_src_rf, ir_src_exec  out  2 each  IR source select for the next stage: DATA, NOP or EXCEPT.
REQ-015 pc_sel  out  3  next-PC select: SEQ, BRANCH, ILLOP, XADDR.
REQ-016 irq_ack  out  1  one-cycle pulse when an interrupt is accepted.

Function
REQ-017 States: RUN, STALL, EXC. Stall counter stall_cnt is 2 bits and saturates at 0.
REQ-018 A load hazard exists when ld_exec or ld_mem is set, and either (use_ra_rf and ra_rf == rc) or (use_rb_rf and rb_rf == rc); a register number of 31 never hazards.
REQ-019 In RUN with an EXEC hazard: load stall_cnt = LD_STALL_EXEC-1 and go to STALL. Otherwise with a MEM-only hazard: load stall_cnt = LD_STALL_MEM-1, and go to STALL only if the loaded value is nonzero, else remain in RUN.
REQ-020 While a hazard or STALL is active: stall_if=1, stall_rf=1, ir_src_rf=NOP, pc_sel=SEQ (PC held by stall_if), ir_src_if=DATA and ir_src_exec=DATA.
REQ-021 In STALL, hazards are re-evaluated every cycle.
  - Leave for RUN when stall_cnt==0 and no hazard remains.
  - A new EXEC hazard reloads the counter.
REQ-022 Priority in RUN: hazard > ill_op_rf > irq > br_taken_rf > normal.
REQ-023 An illegal op (ill_op_rf=1, no hazard) produces, in the same cycle:
  - ir_src_rf=EXCEPT and ir_src_if=NOP;
  - pc_sel=ILLOP;
  - next state EXC.
REQ-024 An interrupt is accepted when irq=1, sup_rf=0, no hazard, no ill_op_rf and state is RUN. It behaves as in REQ-023 but with pc_sel=XADDR, and irq_ack=1 for exactly that cycle.
REQ-025 EXC lasts exactly one cycle:
  - ir_src_if=NOP, all other ir_src=DATA, pc_sel=SEQ;
  - irq is not accepted;
  - then return to RUN.
REQ-026 A taken branch (br_taken_rf, no higher-priority event) sets ir_src_if=NOP and pc_sel=BRANCH; there are no stalls.
REQ-027 br_taken_rf is ignored while a stall is active; the branch re-resolves after the stall releases.
REQ-028 With no event: all ir_src=DATA, pc_sel=SEQ, stalls 0.
REQ-029 All outputs are combinational from state, counter and inputs; no output depends on an unregistered loop.

Reset
REQ-030 While reset=1:
  - state=RUN, stall_cnt=0;
  - stall_if=0, stall_rf=0, irq_ack=0;
  - ir_src_if=NOP, ir_src_rf=NOP, ir_src_exec=NOP;
  - pc_sel=SEQ.
REQ-031 Reset asserted mid-STALL or mid-EXC aborts it immediately. The first cycle after release is RUN.

Structure
REQ-032 IR_SRC_DATA/NOP/EXCEPT codes, PC_SEL codes and the state enumeration are defined in the shared defines file.
REQ-033 Hazard detection is a sub-module, ld_hazard: purely combinational, instantiated once with the EXEC and MEM comparisons.

Verification
REQ-034 LD r1 in EXEC, RF uses ra=1 -> stall_if/stall_rf=1 and ir_src_rf=NOP for exactly 2 cycles, then RUN.
REQ-035 LD r31 in EXEC, RF ra=31 -> no stall, all ir_src=DATA.
REQ-036 ill_op_rf=1 with irq=1 simultaneously -> pc_sel=ILLOP, irq_ack=0, ir_src_rf=EXCEPT; next cycle state EXC with ir_src_if=NOP.
REQ-037 irq=1, sup_rf=0, RUN -> one-cycle irq_ack, pc_sel=XADDR. With irq held, no second ack while sup_rf=1.
REQ-038 br_taken_rf=1 during an EXEC load stall -> pc_sel=SEQ until release; BRANCH is taken on the first RUN cycle.
REQ-039 reset asserted during cycle 1 of a stall -> outputs at reset values immediately; after release, RUN with stall_cnt=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared codes for the pipeline controller: IR source selects, next-PC
// selects, controller states and the hazard-free register number.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        IR_SRC_DATA   = 2'd0,
        IR_SRC_NOP    = 2'd1,
        IR_SRC_EXCEPT = 2'd2
    } ir_src_e;

    typedef enum logic [2:0] {
        PC_SEL_SEQ    = 3'd0,
        PC_SEL_BRANCH = 3'd1,
        PC_SEL_ILLOP  = 3'd2,
        PC_SEL_XADDR  = 3'd3
    } pc_sel_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_EXC   = 2'd2
    } state_e;

    // r31 is the hardwired register, so a load targeting it never blocks anyone
    localparam logic [4:0] REG_NO_HAZARD = 5'd31;

    // Counts down by one but never wraps below zero
    function automatic logic [1:0] satDec(input logic [1:0] value);
        return (value == 2'd0) ? 2'd0 : value - 2'd1;
    endfunction

endpackage

// File: rtl/pipe_ctrl_ld_hazard.sv
// Load-use hazard detector: compares the RF-stage source fields against the
// destinations of loads sitting in EXEC and in MEM. Purely combinational.
module ld_hazard
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] ra_i,
    input  logic [4:0] rb_i,
    input  logic       use_ra_i,
    input  logic       use_rb_i,
    input  logic       ld_exec_i,
    input  logic [4:0] rc_exec_i,
    input  logic       ld_mem_i,
    input  logic [4:0] rc_mem_i,
    output logic       haz_exec_o,
    output logic       haz_mem_o
);

    // True when a load writing rc feeds one of the RF-stage sources
    function automatic logic loadFeeds(input logic       isLoad,
                                       input logic [4:0] rc,
                                       input logic [4:0] ra,
                                       input logic       useRa,
                                       input logic [4:0] rb,
                                       input logic       useRb);
        logic hit;
        hit = (useRa && (ra == rc)) || (useRb && (rb == rc));
        return isLoad && (rc != REG_NO_HAZARD) && hit;
    endfunction

    // Both stage comparisons evaluated side by side every cycle
    always_comb begin
        haz_exec_o = loadFeeds(ld_exec_i, rc_exec_i, ra_i, use_ra_i, rb_i, use_rb_i);
        haz_mem_o  = loadFeeds(ld_mem_i,  rc_mem_i,  ra_i, use_ra_i, rb_i, use_rb_i);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: load-use stalls, illegal-op and interrupt traps, and
// taken-branch redirects for a five-stage pipe. Outputs are combinational
// from the state, the stall counter and the current inputs.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LD_STALL_EXEC = 2,
    parameter int LD_STALL_MEM  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] ra_rf,
    input  logic [4:0] rb_rf,
    input  logic       use_ra_rf,
    input  logic       use_rb_rf,
    input  logic       ld_exec,
    input  logic       ld_mem,
    input  logic [4:0] rc_exec,
    input  logic [4:0] rc_mem,
    input  logic       br_taken_rf,
    input  logic       ill_op_rf,
    input  logic       irq,
    input  logic       sup_rf,
    output logic       stall_if,
    output logic       stall_rf,
    output logic [1:0] ir_src_if,
    output logic [1:0] ir_src_rf,
    output logic [1:0] ir_src_exec,
    output logic [2:0] pc_sel,
    output logic       irq_ack
);

    // The hazard cycle itself is one bubble, so the counter holds the extra
    // STALL-state cycles still owed; STALL is left once it drains to zero.
    localparam logic [1:0] EXEC_LOAD = 2'(LD_STALL_EXEC - 1);
    localparam logic [1:0] MEM_LOAD  = 2'(LD_STALL_MEM - 1);

    state_e     state_q, state_d;
    logic [1:0] stallCnt_q, stallCnt_d;
    logic [1:0] stallDec;
    logic       hazExec;
    logic       hazMem;

    ld_hazard u_ld_hazard (
        .ra_i       (ra_rf),
        .rb_i       (rb_rf),
        .use_ra_i   (use_ra_rf),
        .use_rb_i   (use_rb_rf),
        .ld_exec_i  (ld_exec),
        .rc_exec_i  (rc_exec),
        .ld_mem_i   (ld_mem),
        .rc_mem_i   (rc_mem),
        .haz_exec_o (hazExec),
        .haz_mem_o  (hazMem)
    );

    // State and stall counter registers, cleared asynchronously by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RUN;
            stallCnt_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    // Next-state, counter and output decode; reset forces the quiet outputs
    always_comb begin
        state_d     = state_q;
        stallCnt_d  = stallCnt_q;
        stallDec    = satDec(stallCnt_q);
        stall_if    = 1'b0;
        stall_rf    = 1'b0;
        ir_src_if   = IR_SRC_DATA;
        ir_src_rf   = IR_SRC_DATA;
        ir_src_exec = IR_SRC_DATA;
        pc_sel      = PC_SEL_SEQ;
        irq_ack     = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (hazExec || hazMem) begin
                    stall_if   = 1'b1;
                    stall_rf   = 1'b1;
                    ir_src_rf  = IR_SRC_NOP;
                    stallCnt_d = hazExec ? EXEC_LOAD : MEM_LOAD;
                    state_d    = (stallCnt_d != 2'd0) ? ST_STALL : ST_RUN;
                end else if (ill_op_rf) begin
                    ir_src_if = IR_SRC_NOP;
                    ir_src_rf = IR_SRC_EXCEPT;
                    pc_sel    = PC_SEL_ILLOP;
                    state_d   = ST_EXC;
                end else if (irq && !sup_rf) begin
                    ir_src_if = IR_SRC_NOP;
                    ir_src_rf = IR_SRC_EXCEPT;
                    pc_sel    = PC_SEL_XADDR;
                    irq_ack   = 1'b1;
                    state_d   = ST_EXC;
                end else if (br_taken_rf) begin
                    ir_src_if = IR_SRC_NOP;
                    pc_sel    = PC_SEL_BRANCH;
                end
            end
            ST_STALL: begin
                stall_if  = 1'b1;
                stall_rf  = 1'b1;
                ir_src_rf = IR_SRC_NOP;
                if (hazExec) begin
                    stallCnt_d = EXEC_LOAD;
                end else if (hazMem && (MEM_LOAD > stallDec)) begin
                    stallCnt_d = MEM_LOAD;
                end else begin
                    stallCnt_d = stallDec;
                end
                state_d = (stallCnt_d != 2'd0) ? ST_STALL : ST_RUN;
            end
            ST_EXC: begin
                ir_src_if = IR_SRC_NOP;
                state_d   = ST_RUN;
            end
            default: begin
                state_d    = ST_RUN;
                stallCnt_d = 2'd0;
            end
        endcase

        if (reset) begin
            stall_if    = 1'b0;
            stall_rf    = 1'b0;
            irq_ack     = 1'b0;
            ir_src_if   = IR_SRC_NOP;
            ir_src_rf   = IR_SRC_NOP;
            ir_src_exec = IR_SRC_NOP;
            pc_sel      = PC_SEL_SEQ;
        end
    end

endmodule
